// File: rtl/scores_scanner_pkg.sv
// Shared definitions for the score RAM scanner: state encoding and default
// geometry matching the score RAM instance.
package scores_scanner_pkg;

  localparam int SCORES_DEPTH  = 14;
  localparam int SCORES_DATA_W = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scores_scan_accum.sv
// Registered max / sum / non-zero-count accumulator. clear wins over en;
// strict greater-than keeps the lowest address on equal maxima.
module scores_scan_accum #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 14,
  parameter int SUM_W  = 18,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] max_score,
  output logic [ADDR_W-1:0] max_addr,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  nonzero_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_score     <= '0;
      max_addr      <= '0;
      sum           <= '0;
      nonzero_count <= '0;
    end else if (clear) begin
      max_score     <= '0;
      max_addr      <= '0;
      sum           <= '0;
      nonzero_count <= '0;
    end else if (en) begin
      sum <= sum + SUM_W'(data);
      if (data != '0)
        nonzero_count <= nonzero_count + CNT_W'(1);
      if (data > max_score) begin
        max_score <= data;
        max_addr  <= addr;
      end
    end
  end

endmodule

// File: rtl/scores_scanner.sv
// Walks the score RAM's combinational read port once per start request and
// reports high score, its address, total and non-zero count.
module scores_scanner
  import scores_scanner_pkg::*;
#(
  parameter int DEPTH  = SCORES_DEPTH,
  parameter int DATA_W = SCORES_DATA_W,
  parameter int ADDR_W = 14,
  parameter int SUM_W  = 18,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] read_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_score,
  output logic [ADDR_W-1:0] max_addr,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  nonzero_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] idx;
  logic             acc_clear;
  logic             acc_en;

  assign acc_clear = (state == S_IDLE) && start;
  assign acc_en    = (state == S_SCAN);

  // read_addr is kept as its own register mirroring idx so the RAM address
  // never depends combinationally on start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      read_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          read_addr <= '0;
          done      <= 1'b0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx == LAST_IDX) begin
            idx       <= '0;
            read_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx       <= idx + CNT_W'(1);
            read_addr <= ADDR_W'(idx + CNT_W'(1));
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          idx       <= '0;
          read_addr <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  scores_scan_accum #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk          (clk),
    .reset        (reset),
    .clear        (acc_clear),
    .en           (acc_en),
    .data         (rd_data),
    .addr         (read_addr),
    .max_score    (max_score),
    .max_addr     (max_addr),
    .sum          (sum),
    .nonzero_count(nonzero_count)
  );

endmodule

// File: tb/tb_scores_scanner.sv
// Self-checking bench for scores_scanner with a behavioural combinational-read
// score RAM beside it.
module tb_scores_scanner;

  localparam int DEPTH  = 14;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 14;
  localparam int SUM_W  = 18;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] read_addr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_score;
  logic [ADDR_W-1:0] max_addr;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  nonzero_count;

  logic [DATA_W-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  typedef struct {
    string                        name;
    logic [DEPTH-1:0][DATA_W-1:0] image;
    logic [DATA_W-1:0]            exp_max;
    logic [ADDR_W-1:0]            exp_addr;
    logic [SUM_W-1:0]             exp_sum;
    logic [CNT_W-1:0]             exp_cnt;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  assign rd_data = (read_addr < ADDR_W'(DEPTH)) ? mem[read_addr[3:0]] : '0;

  scores_scanner dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rd_data      (rd_data),
    .read_addr    (read_addr),
    .busy         (busy),
    .done         (done),
    .max_score    (max_score),
    .max_addr     (max_addr),
    .sum          (sum),
    .nonzero_count(nonzero_count)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_results(input int v, input string tag);
    check_output({vecs[v].name, tag, "_max"},  32'(max_score),     32'(vecs[v].exp_max));
    check_output({vecs[v].name, tag, "_addr"}, 32'(max_addr),      32'(vecs[v].exp_addr));
    check_output({vecs[v].name, tag, "_sum"},  32'(sum),           32'(vecs[v].exp_sum));
    check_output({vecs[v].name, tag, "_cnt"},  32'(nonzero_count), 32'(vecs[v].exp_cnt));
  endtask

  task automatic load_image(input int v);
    for (int i = 0; i < DEPTH; i++) mem[i] = vecs[v].image[i];
  endtask

  // One full scan; cycle 1 is the negedge right after the accepting edge.
  task automatic apply_stimulus(input int v, input bit repulse);
    int done_cnt, done_cyc, addr_err;
    load_image(v);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_cyc = 0; addr_err = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= DEPTH && (read_addr !== ADDR_W'(c - 1) || busy !== 1'b1)) addr_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          check_output({vecs[v].name, "_busy_at_done"}, 32'(busy), 32'd0);
          check_results(v, "_at_done");
        end
      end
      start = repulse && (c == 5 || c == 15);
    end
    start = 1'b0;
    check_output({vecs[v].name, "_addr_seq_errs"}, 32'(addr_err), 32'd0);
    check_output({vecs[v].name, "_done_cycle"},    32'(done_cyc), 32'd15);
    check_output({vecs[v].name, "_done_pulses"},   32'(done_cnt), 32'd1);
    check_results(v, "_held");
  endtask

  initial begin
    vecs[0].name = "basic";
    vecs[0].image = '0;
    vecs[0].image[0] = 14'd5;
    vecs[0].image[2] = 14'd300;
    vecs[0].image[3] = 14'd12;
    vecs[0].exp_max = 14'd300; vecs[0].exp_addr = 14'd2;
    vecs[0].exp_sum = 18'd317; vecs[0].exp_cnt = 4'd3;

    vecs[1].name = "tie";
    for (int i = 0; i < DEPTH; i++) vecs[1].image[i] = 14'd1;
    vecs[1].image[4] = 14'd16383;
    vecs[1].image[9] = 14'd16383;
    vecs[1].exp_max = 14'd16383; vecs[1].exp_addr = 14'd4;
    vecs[1].exp_sum = 18'd32778; vecs[1].exp_cnt = 4'd14;

    vecs[2].name = "zeros";
    vecs[2].image = '0;
    vecs[2].exp_max = '0; vecs[2].exp_addr = '0;
    vecs[2].exp_sum = '0; vecs[2].exp_cnt = '0;

    vecs[3].name = "full";
    for (int i = 0; i < DEPTH; i++) vecs[3].image[i] = 14'd16383;
    vecs[3].exp_max = 14'd16383; vecs[3].exp_addr = 14'd0;
    vecs[3].exp_sum = 18'd229362; vecs[3].exp_cnt = 4'd14;

    vecs[4].name = "last_addr";
    vecs[4].image = '0;
    vecs[4].image[12] = 14'd100;
    vecs[4].image[13] = 14'd101;
    vecs[4].exp_max = 14'd101; vecs[4].exp_addr = 14'd13;
    vecs[4].exp_sum = 18'd201; vecs[4].exp_cnt = 4'd2;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    #12;
    check_output("rst_busy",  32'(busy),          32'd0);
    check_output("rst_done",  32'(done),          32'd0);
    check_output("rst_raddr", 32'(read_addr),     32'd0);
    check_output("rst_max",   32'(max_score),     32'd0);
    check_output("rst_maddr", 32'(max_addr),      32'd0);
    check_output("rst_sum",   32'(sum),           32'd0);
    check_output("rst_cnt",   32'(nonzero_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) apply_stimulus(v, 1'b0);

    // Reset in the middle of a scan aborts without a done pulse.
    begin
      int late_done;
      load_image(0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("abort_busy",  32'(busy),          32'd0);
      check_output("abort_done",  32'(done),          32'd0);
      check_output("abort_raddr", 32'(read_addr),     32'd0);
      check_output("abort_max",   32'(max_score),     32'd0);
      check_output("abort_maddr", 32'(max_addr),      32'd0);
      check_output("abort_sum",   32'(sum),           32'd0);
      check_output("abort_cnt",   32'(nonzero_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      late_done = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) late_done++;
      end
      check_output("abort_no_done", 32'(late_done), 32'd0);
    end
    apply_stimulus(0, 1'b0);

    // Re-pulsing start during SCAN and DONE must not queue a second scan.
    apply_stimulus(0, 1'b1);
    begin
      int extra;
      extra = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      check_output("repulse_no_rescan", 32'(extra), 32'd0);
    end

    // Held start: back-to-back scans with one IDLE cycle between them.
    begin
      int dcnt, derr, aerr, p;
      load_image(3);
      @(negedge clk);
      start = 1'b1;
      dcnt = 0; derr = 0; aerr = 0;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (c == 40) start = 1'b0;
        if (done === 1'b1) begin
          dcnt++;
          if (c != 15 && c != 31 && c != 47) derr++;
        end
        if (c <= 47) begin
          p = (c - 1) % 16;
          if (read_addr !== ADDR_W'((p < DEPTH) ? p : 0)) aerr++;
        end
      end
      check_output("held_done_count",   32'(dcnt), 32'd3);
      check_output("held_done_spacing", 32'(derr), 32'd0);
      check_output("held_addr_seq",     32'(aerr), 32'd0);
      check_results(3, "_held_start");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
